// File: rtl/arbiter_round_robin_binary_registered.sv
// Round-robin arbiter over INPUT_COUNT valid/ready channels with a one-entry registered output
// carrying the winning word and its binary channel index; 1-cycle latency, full rate under out_ready.
module arbiter_round_robin_binary_registered #(
    parameter int WORD_WIDTH  = 8,
    parameter int INPUT_COUNT = 4,
    parameter int ADDR_WIDTH  = 2,
    parameter int TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic [INPUT_COUNT-1:0] in_valid,
    output logic [INPUT_COUNT-1:0] in_ready,
    input  logic [TOTAL_WIDTH-1:0] words_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_WIDTH-1:0]  word_out,
    output logic [ADDR_WIDTH-1:0]  selector_out
);

    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    logic                  found;
    logic [ADDR_WIDTH-1:0] grant;
    logic [WORD_WIDTH-1:0] word_sel;
    logic                  load;

    // Circular search starting at the pointer; the index wraps at INPUT_COUNT, not at 2**ADDR_WIDTH.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int j = 0; j < INPUT_COUNT; j++) begin
            idx = int'(ptr_q) + j;
            if (idx >= INPUT_COUNT) idx = idx - INPUT_COUNT;
            for (int i = 0; i < INPUT_COUNT; i++) begin
                if (!found && idx == i && in_valid[i]) begin
                    found = 1'b1;
                    grant = i[ADDR_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            if (int'(grant) == i) word_sel = words_in[i*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    assign load = clear_n & (~out_valid_q | out_ready) & found;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            in_ready[i] = load & (int'(grant) == i);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        word_d      = word_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            word_d      = word_sel;
            sel_d       = grant;
            if (int'(grant) == INPUT_COUNT - 1) ptr_d = '0;
            else                                ptr_d = grant + ADDR_WIDTH'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            out_valid_q <= 1'b0;
            word_q      <= '0;
            sel_q       <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            word_q      <= word_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign word_out     = word_q;
    assign selector_out = sel_q;

endmodule

// File: doc/arbiter_round_robin_binary_registered.md
Name: arbiter_round_robin_binary_registered

Overview:
- Upstream selection stage for the binary multiplexer.
- Arbitrates INPUT_COUNT valid/ready source channels round-robin and registers the winning word.
- Presents the winner's binary index on `selector_out`, which drives a downstream binary multiplexer's selector (e.g. a sideband data path), with a matching valid/ready output.
- One-entry output buffer; full throughput of one transfer per cycle under continuous `out_ready`.

Parameters:
- WORD_WIDTH, 8, width of each input word and of `word_out`.
- INPUT_COUNT, 4, number of source channels; any value ≥2, not restricted to powers of two.
- ADDR_WIDTH, 2, width of `selector_out`; must satisfy 2**ADDR_WIDTH ≥ INPUT_COUNT.
- TOTAL_WIDTH, WORD_WIDTH*INPUT_COUNT, derived; do not set at instantiation.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- clear_n  in  1  synchronous, active-low reset.
- in_valid  in  INPUT_COUNT  per-channel valid; bit i belongs to channel i.
- in_ready  out  INPUT_COUNT  per-channel ready; at most one bit high per cycle.
- words_in  in  TOTAL_WIDTH  concatenated channel words; channel 0 in the LSBs.
- out_valid  out  1  `word_out` and `selector_out` hold a valid entry.
- out_ready  in  1  downstream accepts the entry this cycle.
- word_out  out  WORD_WIDTH  registered winning word.
- selector_out  out  ADDR_WIDTH  registered binary index of the winning channel.

Behaviour:
- Reset (clear_n=0 at a clock edge) has priority over every other event, including a pending entry or a mid-handshake. Results: out_valid=0, word_out=0, selector_out=0, round-robin pointer=0. Any pending entry is discarded.
- in_ready: combinational; all zero while clear_n=0.
- Transfers:
  - Input transfer on channel i when in_valid[i] & in_ready[i].
  - Output transfer when out_valid & out_ready.
- Load condition: `load = (!out_valid | out_ready) & |in_valid`.
  - A simultaneous drain and load in the same cycle is legal and sustains 1 word/cycle.
- Grant: the first channel with in_valid set, searching circularly from pointer p through p, p+1, …, INPUT_COUNT-1, 0, …, p-1.
  - in_ready[grant] = load. All other in_ready bits = 0.
  - in_ready never depends on in_valid of the same channel beyond grant selection. No valid-without-ready combinational loop through out_ready beyond the load term.
- On load, at the next edge:
  - word_out ← words_in[grant*WORD_WIDTH +: WORD_WIDTH]
  - selector_out ← grant
  - out_valid ← 1
  - pointer ← grant+1, wrapping to 0 when grant = INPUT_COUNT-1; this is an explicit compare, not a modulo-2**ADDR_WIDTH wrap.
- On output transfer with no load: out_valid ← 0. word_out and selector_out hold their last values.
- No load: pointer unchanged, even while stalled.
- Latency: input transfer to out_valid is 1 cycle.
- While out_valid & !out_ready:
  - word_out, selector_out and out_valid are stable.
  - All in_ready = 0.
- Starvation bound: a channel holding in_valid is granted within INPUT_COUNT loads.
- Sources may change or drop words/valid when not granted. The block makes no assumption of source stability.
- selector_out never exceeds INPUT_COUNT-1.

Test Plan:
1. Reset: hold clear_n=0 for 2 cycles with all in_valid=1 → in_ready=0000, out_valid=0, word_out=0, selector_out=0. Release, out_ready=1 → first grant is channel 0.
2. Round-robin fairness (INPUT_COUNT=4): all in_valid=1111, words 0xA0..0xA3, out_ready=1 continuously → selector_out sequence 0,1,2,3,0,1 on consecutive cycles; word_out 0xA0,0xA1,0xA2,0xA3,0xA0; out_valid stays 1.
3. Backpressure: after one load, out_ready=0 for 3 cycles → entry stable and in_ready=0000 throughout. Raise out_ready → the same entry drains, and the next channel loads in the same cycle.
4. Sparse requests and wrap: pointer=3, in_valid=0010 → channel 1 granted and pointer becomes 2. Then in_valid=0001 → channel 0 granted via wrap.
5. Non-power-of-two (INPUT_COUNT=3, ADDR_WIDTH=2): all valid → selector_out 0,1,2,0, never 3.
6. Reset mid-operation: out_valid=1 with out_ready=0, then assert clear_n=0 for 1 cycle → out_valid=0 and the pointer returns to 0; after release, all-valid gives grant 0.
